// File: rtl/jtag_unlock_ctrl_pkg.sv
// Shared debug-module definitions: DMI op/response encodings, HMAC message
// layout and the unlock sequencer state encoding.
package jtag_unlock_ctrl_pkg;

  typedef enum logic [1:0] {
    DmiNop   = 2'h0,
    DmiRead  = 2'h1,
    DmiWrite = 2'h2
  } dmi_op_e;

  typedef enum logic [1:0] {
    DmiRespSuccess = 2'h0,
    DmiRespFailed  = 2'h2,
    DmiRespBusy    = 2'h3
  } dmi_resp_e;

  localparam int unsigned PassWidth   = 32;
  localparam int unsigned HashWidth   = 256;
  localparam int unsigned MsgPadWidth = 480;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StWaitReady = 3'd1;
  localparam logic [2:0] StWaitBusy  = 3'd2;
  localparam logic [2:0] StWaitValid = 3'd3;
  localparam logic [2:0] StCompare   = 3'd4;
  localparam logic [2:0] StLockout   = 3'd5;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jtag_unlock_ctrl.sv
// Debug-unlock sequencer: runs the password through the shared HMAC engine,
// compares against the expected digest, and rate-limits failed attempts.
module jtag_unlock_ctrl
  import jtag_unlock_ctrl_pkg::*;
#(
  parameter int unsigned MaxFails      = 3,
  parameter int unsigned LockoutCycles = 1024,
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic                             tck_i,
  input  logic                             trst_ni,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [31:0]                      req_pass_i,
  input  logic                             relock_i,
  input  logic [255:0]                     exp_hash_i,
  output logic                             hmac_init_o,
  output logic [511:0]                     hmac_msg_o,
  input  logic                             hmac_ready_i,
  input  logic                             hmac_valid_i,
  input  logic [255:0]                     hmac_hash_i,
  output logic                             unlock_o,
  output logic                             locked_out_o,
  output logic                             done_o,
  output logic                             pass_ok_o,
  output logic [$clog2(MaxFails+1)-1:0]    fail_cnt_o
);

  localparam int unsigned CntMax = max_u(LockoutCycles, TimeoutCycles);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned FailW  = $clog2(MaxFails + 1);

  localparam logic [CntW-1:0]  TimeoutLoad = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0]  LockoutLoad = CntW'(LockoutCycles - 1);
  localparam logic [FailW-1:0] FailLimit   = FailW'(MaxFails);

  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [PassWidth-1:0] pass_q, pass_d;
  logic [HashWidth-1:0] hash_q, hash_d;
  logic [FailW-1:0]     fail_q, fail_d;
  logic                 init_q, init_d;
  logic                 timeout_q, timeout_d;
  logic                 unlock_q, unlock_d;
  logic                 done_q, done_d;
  logic                 pass_ok_q, pass_ok_d;

  logic                 cnt_zero;
  logic                 hash_match;
  logic [FailW-1:0]     fail_inc;

  assign cnt_zero   = (cnt_q == '0);
  // A watchdog expiry reuses COMPARE with a forced mismatch.
  assign hash_match = !timeout_q && (hash_q == exp_hash_i);
  assign fail_inc   = (fail_q == FailLimit) ? fail_q : fail_q + FailW'(1);

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    hash_d    = hash_q;
    fail_d    = fail_q;
    init_d    = init_q;
    timeout_d = timeout_q;
    unlock_d  = unlock_q;
    done_d    = 1'b0;
    pass_ok_d = pass_ok_q;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          pass_d    = req_pass_i;
          cnt_d     = TimeoutLoad;
          timeout_d = 1'b0;
          state_d   = StWaitReady;
        end
      end

      StWaitReady: begin
        if (hmac_ready_i) begin
          init_d  = 1'b1;
          cnt_d   = TimeoutLoad;
          state_d = StWaitBusy;
        end else if (cnt_zero) begin
          init_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = StCompare;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StWaitBusy: begin
        // Init is held until the engine shows it has left idle.
        if (!hmac_ready_i) begin
          init_d  = 1'b0;
          cnt_d   = TimeoutLoad;
          state_d = StWaitValid;
        end else if (cnt_zero) begin
          init_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = StCompare;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StWaitValid: begin
        if (hmac_valid_i) begin
          hash_d  = hmac_hash_i;
          state_d = StCompare;
        end else if (cnt_zero) begin
          timeout_d = 1'b1;
          state_d   = StCompare;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StCompare: begin
        done_d    = 1'b1;
        pass_ok_d = hash_match;
        timeout_d = 1'b0;
        if (hash_match) begin
          unlock_d = 1'b1;
          fail_d   = '0;
          state_d  = StIdle;
        end else begin
          unlock_d = 1'b0;
          fail_d   = fail_inc;
          if (fail_inc == FailLimit) begin
            cnt_d   = LockoutLoad;
            state_d = StLockout;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StLockout: begin
        if (cnt_zero) begin
          fail_d  = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    // Relock overrides any unlock decided this cycle.
    if (relock_i) unlock_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pass_q    <= '0;
      hash_q    <= '0;
      fail_q    <= '0;
      init_q    <= 1'b0;
      timeout_q <= 1'b0;
      unlock_q  <= 1'b0;
      done_q    <= 1'b0;
      pass_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      hash_q    <= hash_d;
      fail_q    <= fail_d;
      init_q    <= init_d;
      timeout_q <= timeout_d;
      unlock_q  <= unlock_d;
      done_q    <= done_d;
      pass_ok_q <= pass_ok_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign locked_out_o = (state_q == StLockout);
  assign hmac_init_o  = init_q;
  assign hmac_msg_o   = {{MsgPadWidth{1'b0}}, pass_q};
  assign unlock_o     = unlock_q;
  assign done_o       = done_q;
  assign pass_ok_o    = pass_ok_q;
  assign fail_cnt_o   = fail_q;

endmodule
